fetch_unit: RTL and testbench
=============================

# fetch_unit

Instruction-fetch stage of the 5-stage MIPS pipeline. It owns the PC, issues requests to instruction memory over a req/ready handshake, and drives the IF/ID pipeline register. It sits directly upstream of the decode stage and consumes the hazard unit's Stall_IF/Stall_ID outputs and the EX-stage branch/jump redirect. A hold buffer absorbs an instruction that returns while decode is stalled; a drop state discards a fetch made stale by a redirect.

## Interface
- ADDR_WIDTH, 32, PC and memory address width
- DATA_WIDTH, 32, instruction width
- RESET_PC, 32'h0040_0000, first fetch address after reset
- clk  in  1  pipeline clock, rising edge
- reset  in  1  asynchronous, active-low; clears all state
- Stall_IF  in  1  hazard unit: PC must not advance
- Stall_ID  in  1  hazard unit: IF/ID register must hold
- Redirect  in  1  taken branch/jump resolved in EX
- Redirect_PC  in  ADDR_WIDTH  target of Redirect
- imem_req  out  1  fetch request
- imem_addr  out  ADDR_WIDTH  fetch address; stable while imem_req=1
- imem_ready  in  1  imem_rdata valid this cycle; may rise in the same cycle as imem_req
- imem_rdata  in  DATA_WIDTH  fetched instruction
- Instr_ID  out  DATA_WIDTH  IF/ID instruction
- PC_plus4_ID  out  ADDR_WIDTH  IF/ID PC+4
- Valid_ID  out  1  IF/ID holds a real instruction (0 = bubble)

## Operation
- Reset values: PC=RESET_PC, state=FETCH, Instr_ID=0, PC_plus4_ID=0, Valid_ID=0, hold buffer=0. imem_req=0 while reset is low.
- imem_req and imem_addr are Moore outputs of the state and PC registers. Once imem_req is raised, it stays high with a constant address until imem_ready.
- "Accept" means the IF/ID register loads {instr, PC+4, Valid=1} and PC <= PC+4. Accept happens only when Stall_ID=0 and Stall_IF=0.
- FETCH: imem_req=1.
  - ready & Redirect: discard data, PC<=Redirect_PC, stay in FETCH.
  - ready & stalled: capture data into the hold buffer, go to HOLD.
  - ready & not stalled: accept.
  - no ready & Redirect: latch Redirect_PC into pending_pc, go to DROP.
- HOLD: imem_req=0.
  - Redirect: discard the buffer, PC<=Redirect_PC, go to FETCH.
  - Stall released: accept from the buffer, go to FETCH.
- DROP: imem_req=1 at the old address.
  - Any Redirect updates pending_pc; the latest redirect wins.
  - On ready: discard data, PC<=pending_pc, go to FETCH.
- IF/ID update rule, in priority order:
  1. Redirect: flush (Instr_ID=0, Valid_ID=0, PC_plus4_ID=0). Redirect overrides Stall_ID.
  2. Stall_ID: hold.
  3. Accept: load.
  4. Otherwise: bubble (Valid_ID=0, Instr_ID=0).
- PC arithmetic is modulo 2^ADDR_WIDTH; 32'hFFFF_FFFC+4 wraps to 0. Bits [1:0] are not checked.

## Timing
- Zero-wait memory (ready in the request cycle): one instruction per cycle. A request and ready in cycle n put Instr_ID out at n+1.
- Redirect in cycle n: IF/ID is flushed at n+1, and the first request to Redirect_PC is issued at n+1. In DROP, that request is issued the cycle after the stale ready.
- HOLD release: the buffered instruction reaches IF/ID one cycle after the stall drops, and the next request is issued that same cycle.
- Asynchronous reset mid-request abandons the outstanding fetch. The memory side must tolerate req dropping without ready during reset.

## Structure
- Shared package/header: state encoding (FETCH=2'd0, HOLD=2'd1, DROP=2'd2), NOP constant 32'h0000_0000, default RESET_PC.
- One natural sub-module: if_id_register (enable, flush, async active-low reset), reused for the other stage registers.

## Test plan
- Reset, then zero-wait memory returning 0x2000_0001… → Instr_ID sequence matches; PC_plus4_ID = 0x0040_0004, 0x0040_0008, …; Valid_ID=1 from the second cycle.
- Stall_ID=Stall_IF=1 for 3 cycles while ready returns 0x8C08_0000 → state HOLD, imem_req=0, IF/ID unchanged; on release, Instr_ID=0x8C08_0000 next cycle, no duplicate.
- Redirect to 0x0040_0100 during a 3-cycle-latency fetch of 0x0040_0010 → DROP; the stale ready is discarded; next imem_addr=0x0040_0100; Valid_ID=0 for the flushed slot.
- Redirect and Stall_ID together with data in HOLD → buffer discarded, IF/ID flushed, next imem_addr = Redirect_PC.
- Two redirects in DROP (0x100, then 0x200) → fetch resumes at 0x200.
- PC=0xFFFF_FFFC accepted → PC_plus4_ID=0, next imem_addr=0; reset asserted mid-wait → all outputs return to reset values immediately.

Source files
------------

// File: rtl/fetch_unit_pkg.sv
// Shared definitions for the instruction-fetch stage: state encoding,
// the bubble instruction and the default boot address.
package fetch_unit_pkg;

  typedef enum logic [1:0] {
    FETCH = 2'd0,
    HOLD  = 2'd1,
    DROP  = 2'd2
  } fetch_state_t;

  localparam logic [31:0] NOP              = 32'h0000_0000;
  localparam logic [31:0] DEFAULT_RESET_PC = 32'h0040_0000;

endpackage

// File: rtl/if_id_register.sv
// Generic pipeline stage register with hold (en=0) and flush-to-zero,
// flush taking priority over enable.
module if_id_register #(
  parameter int WIDTH = 65
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  input  logic             flush,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)      q <= '0;
    else if (flush)  q <= '0;
    else if (en)     q <= d;
  end

endmodule

// File: rtl/fetch_unit.sv
// MIPS IF stage: owns the PC, requests instructions over req/ready and
// loads IF/ID; HOLD parks a stalled return, DROP swallows a redirected one.
module fetch_unit
  import fetch_unit_pkg::*;
#(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32,
  parameter logic [ADDR_WIDTH-1:0] RESET_PC = ADDR_WIDTH'(DEFAULT_RESET_PC)
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  Stall_IF,
  input  logic                  Stall_ID,
  input  logic                  Redirect,
  input  logic [ADDR_WIDTH-1:0] Redirect_PC,
  output logic                  imem_req,
  output logic [ADDR_WIDTH-1:0] imem_addr,
  input  logic                  imem_ready,
  input  logic [DATA_WIDTH-1:0] imem_rdata,
  output logic [DATA_WIDTH-1:0] Instr_ID,
  output logic [ADDR_WIDTH-1:0] PC_plus4_ID,
  output logic                  Valid_ID
);

  fetch_state_t            state_p0;
  logic [ADDR_WIDTH-1:0]   pc_p0;
  logic [ADDR_WIDTH-1:0]   pending_pc_p0;
  logic [DATA_WIDTH-1:0]   hold_buf_p0;

  logic                    stall;
  logic [ADDR_WIDTH-1:0]   pc_plus4;
  logic                    accept_fetch;
  logic                    accept_hold;
  logic                    accept;
  logic [DATA_WIDTH-1:0]   accept_instr;
  logic [DATA_WIDTH+ADDR_WIDTH:0] if_id_d;

  assign stall        = Stall_IF | Stall_ID;
  assign pc_plus4     = pc_p0 + ADDR_WIDTH'(4);
  assign accept_fetch = (state_p0 == FETCH) & imem_ready & ~Redirect & ~stall;
  assign accept_hold  = (state_p0 == HOLD) & ~Redirect & ~stall;
  assign accept       = accept_fetch | accept_hold;
  assign accept_instr = accept_hold ? hold_buf_p0 : imem_rdata;

  // Request is a Moore output of the state; forced low while reset is held.
  assign imem_req  = reset & (state_p0 != HOLD);
  assign imem_addr = pc_p0;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_p0      <= FETCH;
      pc_p0         <= RESET_PC;
      pending_pc_p0 <= '0;
      hold_buf_p0   <= '0;
    end else begin
      case (state_p0)
        FETCH: begin
          if (imem_ready) begin
            if (Redirect) begin
              pc_p0 <= Redirect_PC;
            end else if (stall) begin
              hold_buf_p0 <= imem_rdata;
              state_p0    <= HOLD;
            end else begin
              pc_p0 <= pc_plus4;
            end
          end else if (Redirect) begin
            pending_pc_p0 <= Redirect_PC;
            state_p0      <= DROP;
          end
        end
        HOLD: begin
          if (Redirect) begin
            pc_p0    <= Redirect_PC;
            state_p0 <= FETCH;
          end else if (!stall) begin
            pc_p0    <= pc_plus4;
            state_p0 <= FETCH;
          end
        end
        DROP: begin
          // A redirect in the same cycle as the stale ready is the latest one.
          if (imem_ready) begin
            pc_p0    <= Redirect ? Redirect_PC : pending_pc_p0;
            state_p0 <= FETCH;
          end else if (Redirect) begin
            pending_pc_p0 <= Redirect_PC;
          end
        end
        default: state_p0 <= FETCH;
      endcase
    end
  end

  // IF/ID boundary: flush on redirect, hold on Stall_ID, else load or bubble.
  assign if_id_d = accept ? {1'b1, accept_instr, pc_plus4}
                          : {1'b0, DATA_WIDTH'(NOP), {ADDR_WIDTH{1'b0}}};

  if_id_register #(
    .WIDTH(DATA_WIDTH + ADDR_WIDTH + 1)
  ) u_if_id (
    .clk   (clk),
    .rst_n (reset),
    .en    (~Stall_ID),
    .flush (Redirect),
    .d     (if_id_d),
    .q     ({Valid_ID, Instr_ID, PC_plus4_ID})
  );

endmodule

// File: tb/tb_fetch_unit.sv
// Bench for fetch_unit: directed vector table, reset corner, then random
// traffic against a queue-based model of the fetch rules.
module tb_fetch_unit;

  logic        clk = 1'b0;
  logic        reset;
  logic        Stall_IF, Stall_ID, Redirect, imem_ready;
  logic [31:0] Redirect_PC, imem_rdata;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic [31:0] Instr_ID, PC_plus4_ID;
  logic        Valid_ID;

  always #5 clk = ~clk;

  fetch_unit dut (
    .clk         (clk),
    .reset       (reset),
    .Stall_IF    (Stall_IF),
    .Stall_ID    (Stall_ID),
    .Redirect    (Redirect),
    .Redirect_PC (Redirect_PC),
    .imem_req    (imem_req),
    .imem_addr   (imem_addr),
    .imem_ready  (imem_ready),
    .imem_rdata  (imem_rdata),
    .Instr_ID    (Instr_ID),
    .PC_plus4_ID (PC_plus4_ID),
    .Valid_ID    (Valid_ID)
  );

  int n_chk  = 0;
  int n_fail = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  typedef struct {
    logic        sif, sid, rd;
    logic [31:0] rpc;
    logic        rdy;
    logic [31:0] data;
    logic        exp_req;
    logic [31:0] exp_addr, exp_instr, exp_pc4;
    logic        exp_valid;
  } vec_t;

  vec_t vecs[$];

  task automatic addv(input logic sif, sid, rd, input logic [31:0] rpc, input logic rdy,
                      input logic [31:0] data, input logic ereq, input logic [31:0] eaddr,
                      input logic [31:0] einstr, epc4, input logic evalid);
    vec_t v;
    v.sif = sif; v.sid = sid; v.rd = rd; v.rpc = rpc; v.rdy = rdy; v.data = data;
    v.exp_req = ereq; v.exp_addr = eaddr; v.exp_instr = einstr; v.exp_pc4 = epc4;
    v.exp_valid = evalid;
    vecs.push_back(v);
  endtask

  task automatic drive(input logic sif, sid, rd, input logic [31:0] rpc, input logic rdy,
                       input logic [31:0] data);
    @(negedge clk);
    Stall_IF = sif; Stall_ID = sid; Redirect = rd; Redirect_PC = rpc;
    imem_ready = rdy; imem_rdata = data;
  endtask

  // Reference model: PC, a queue standing in for the hold buffer, a pending
  // redirect target while a stale fetch drains, and the IF/ID contents.
  logic [31:0] m_pc, m_pending, m_instr, m_pc4;
  logic        m_drop, m_valid;
  logic [31:0] m_buf[$];

  task automatic model_reset();
    m_pc = 32'h0040_0000; m_pending = '0; m_drop = 1'b0;
    m_buf.delete();
    m_instr = '0; m_pc4 = '0; m_valid = 1'b0;
  endtask

  task automatic model_step(input logic sif, sid, rd, input logic [31:0] rpc, input logic rdy,
                            input logic [31:0] data);
    logic        stall;
    logic        acc;
    logic [31:0] ai;
    stall = sif | sid;
    acc   = 1'b0;
    ai    = '0;
    if (m_buf.size() != 0) begin
      if (rd) begin m_buf.delete(); m_pc = rpc; end
      else if (!stall) begin acc = 1'b1; ai = m_buf.pop_front(); end
    end else if (m_drop) begin
      if (rd) m_pending = rpc;
      if (rdy) begin m_pc = m_pending; m_drop = 1'b0; end
    end else if (rdy) begin
      if (rd) m_pc = rpc;
      else if (stall) m_buf.push_back(data);
      else begin acc = 1'b1; ai = data; end
    end else if (rd) begin
      m_drop = 1'b1; m_pending = rpc;
    end
    if (rd) begin
      m_instr = '0; m_pc4 = '0; m_valid = 1'b0;
    end else if (!sid) begin
      if (acc) begin
        m_instr = ai; m_pc4 = m_pc + 32'd4; m_valid = 1'b1; m_pc = m_pc + 32'd4;
      end else begin
        m_instr = '0; m_pc4 = '0; m_valid = 1'b0;
      end
    end
  endtask

  initial begin
    reset = 1'b0;
    Stall_IF = 0; Stall_ID = 0; Redirect = 0; Redirect_PC = '0;
    imem_ready = 0; imem_rdata = '0;

    //   sif sid rd  rpc           rdy data           req addr           instr          pc4            v
    addv(0, 0, 0, 32'h0,          1, 32'h2000_0001, 1, 32'h0040_0000, 32'h2000_0001, 32'h0040_0004, 1);
    addv(0, 0, 0, 32'h0,          1, 32'h2000_0002, 1, 32'h0040_0004, 32'h2000_0002, 32'h0040_0008, 1);
    addv(0, 0, 0, 32'h0,          1, 32'h2000_0003, 1, 32'h0040_0008, 32'h2000_0003, 32'h0040_000C, 1);
    addv(1, 1, 0, 32'h0,          1, 32'h8C08_0000, 1, 32'h0040_000C, 32'h2000_0003, 32'h0040_000C, 1);
    addv(1, 1, 0, 32'h0,          0, 32'h0,         0, 32'h0040_000C, 32'h2000_0003, 32'h0040_000C, 1);
    addv(1, 1, 0, 32'h0,          0, 32'h0,         0, 32'h0040_000C, 32'h2000_0003, 32'h0040_000C, 1);
    addv(0, 0, 0, 32'h0,          0, 32'h0,         0, 32'h0040_000C, 32'h8C08_0000, 32'h0040_0010, 1);
    addv(0, 0, 1, 32'h0040_0100,  0, 32'h0,         1, 32'h0040_0010, 32'h0,         32'h0,         0);
    addv(0, 0, 0, 32'h0,          0, 32'h0,         1, 32'h0040_0010, 32'h0,         32'h0,         0);
    addv(0, 0, 0, 32'h0,          1, 32'hDEAD_BEEF, 1, 32'h0040_0010, 32'h0,         32'h0,         0);
    addv(0, 0, 0, 32'h0,          1, 32'h1111_1111, 1, 32'h0040_0100, 32'h1111_1111, 32'h0040_0104, 1);
    addv(0, 1, 0, 32'h0,          1, 32'h2222_2222, 1, 32'h0040_0104, 32'h1111_1111, 32'h0040_0104, 1);
    addv(0, 1, 1, 32'h0040_0300,  0, 32'h0,         0, 32'h0040_0104, 32'h0,         32'h0,         0);
    addv(0, 0, 0, 32'h0,          1, 32'h3333_3333, 1, 32'h0040_0300, 32'h3333_3333, 32'h0040_0304, 1);
    addv(0, 0, 1, 32'h0000_0100,  0, 32'h0,         1, 32'h0040_0304, 32'h0,         32'h0,         0);
    addv(0, 0, 1, 32'h0000_0200,  0, 32'h0,         1, 32'h0040_0304, 32'h0,         32'h0,         0);
    addv(0, 0, 0, 32'h0,          1, 32'h4444_4444, 1, 32'h0040_0304, 32'h0,         32'h0,         0);
    addv(0, 0, 0, 32'h0,          1, 32'h5555_5555, 1, 32'h0000_0200, 32'h5555_5555, 32'h0000_0204, 1);
    addv(0, 0, 1, 32'hFFFF_FFFC,  1, 32'h6666_6666, 1, 32'h0000_0204, 32'h0,         32'h0,         0);
    addv(0, 0, 0, 32'h0,          1, 32'h7777_7777, 1, 32'hFFFF_FFFC, 32'h7777_7777, 32'h0000_0000, 1);
    addv(0, 1, 0, 32'h0,          0, 32'h0,         1, 32'h0000_0000, 32'h7777_7777, 32'h0000_0000, 1);

    repeat (2) @(posedge clk);
    #1;
    check("rst_req",   {31'b0, imem_req}, 32'd0);
    check("rst_valid", {31'b0, Valid_ID}, 32'd0);
    check("rst_instr", Instr_ID, 32'h0);
    check("rst_pc4",   PC_plus4_ID, 32'h0);
    check("rst_addr",  imem_addr, 32'h0040_0000);
    @(negedge clk);
    reset = 1'b1;

    foreach (vecs[i]) begin
      drive(vecs[i].sif, vecs[i].sid, vecs[i].rd, vecs[i].rpc, vecs[i].rdy, vecs[i].data);
      #1;
      check($sformatf("v%0d_req", i), {31'b0, imem_req}, {31'b0, vecs[i].exp_req});
      check($sformatf("v%0d_addr", i), imem_addr, vecs[i].exp_addr);
      @(posedge clk);
      #1;
      check($sformatf("v%0d_instr", i), Instr_ID, vecs[i].exp_instr);
      check($sformatf("v%0d_valid", i), {31'b0, Valid_ID}, {31'b0, vecs[i].exp_valid});
      if (vecs[i].exp_valid || vecs[i].rd)
        check($sformatf("v%0d_pc4", i), PC_plus4_ID, vecs[i].exp_pc4);
    end

    // Asynchronous reset while a request is outstanding and IF/ID is valid.
    #2 reset = 1'b0;
    #1;
    check("midrst_req",   {31'b0, imem_req}, 32'd0);
    check("midrst_valid", {31'b0, Valid_ID}, 32'd0);
    check("midrst_instr", Instr_ID, 32'h0);
    check("midrst_addr",  imem_addr, 32'h0040_0000);
    Stall_ID = 1'b0;
    @(negedge clk);
    reset = 1'b1;
    #1;
    check("postrst_req", {31'b0, imem_req}, 32'd1);

    begin
      int          cnt;
      int          lat;
      logic        sif, sid, rd, rdy, rq;
      logic [31:0] rpc, data;
      model_reset();
      cnt = 0;
      lat = int'($urandom_range(0, 3));
      for (int i = 0; i < 3000; i++) begin
        rq   = (m_buf.size() == 0);
        sif  = ($urandom_range(0, 5) == 0);
        sid  = ($urandom_range(0, 4) == 0);
        rd   = ($urandom_range(0, 9) == 0);
        rpc  = ($urandom_range(0, 7) == 0) ? 32'hFFFF_FFF8 : ($urandom & 32'hFFFF_FFFC);
        data = $urandom;
        rdy  = rq && (cnt >= lat);
        if (rq) begin
          if (rdy) begin cnt = 0; lat = int'($urandom_range(0, 3)); end
          else cnt++;
        end
        drive(sif, sid, rd, rpc, rdy, data);
        #1;
        check("rnd_req",  {31'b0, imem_req}, {31'b0, rq});
        check("rnd_addr", imem_addr, m_pc);
        @(posedge clk);
        model_step(sif, sid, rd, rpc, rdy, data);
        #1;
        check("rnd_instr", Instr_ID, m_instr);
        check("rnd_valid", {31'b0, Valid_ID}, {31'b0, m_valid});
        if (m_valid || rd) check("rnd_pc4", PC_plus4_ID, m_pc4);
      end
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
